// File: rtl/video_timing_pkg.sv
// rtl/video_timing_pkg.sv - shared constants and types for the raster timing generator
package video_timing_pkg;

   localparam int H_W = 12;
   localparam int V_W = 11;

   localparam int DEF_H_ACTIVE = 1680;
   localparam int DEF_H_FP     = 48;
   localparam int DEF_H_SYNC   = 32;
   localparam int DEF_H_BP     = 80;
   localparam int DEF_V_ACTIVE = 1050;
   localparam int DEF_V_FP     = 3;
   localparam int DEF_V_SYNC   = 6;
   localparam int DEF_V_BP     = 21;

   localparam logic DEF_HSYNC_POL = 1'b1;
   localparam logic DEF_VSYNC_POL = 1'b0;

   localparam int DEF_LOCK_WAIT = 1024;

   typedef enum logic {
      WAIT = 1'b0,
      RUN  = 1'b1
   } vt_state_t;

endpackage

// File: rtl/lock_qualifier.sv
// rtl/lock_qualifier.sv - synchronises PLL lock and holds off the raster until lock is stable
module lock_qualifier
   import video_timing_pkg::*;
#(
   parameter int LOCK_WAIT = DEF_LOCK_WAIT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic pll_locked,
   output logic lock_s,
   output logic lock_ok
);

   localparam int CW = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(LOCK_WAIT - 1);

   logic            sync1_q;
   logic            sync2_q;
   vt_state_t       state_q;
   vt_state_t       state_d;
   logic [CW-1:0]   cnt_q;
   logic [CW-1:0]   cnt_d;

   // Two-flop synchroniser for the asynchronous lock flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= pll_locked;
         sync2_q <= sync1_q;
      end
   end

   assign lock_s = sync2_q;

   // State and lock-counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= WAIT;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state: start after a full stable-lock window, drop out on any loss of lock
   always_comb begin
      state_d = state_q;
      case (state_q)
         WAIT:    if (lock_s && (cnt_q == CNT_LAST)) state_d = RUN;
         RUN:     if (!lock_s) state_d = WAIT;
         default: state_d = WAIT;
      endcase
   end

   // Lock counter: counts consecutive locked cycles in WAIT, any gap restarts it
   always_comb begin
      cnt_d = '0;
      if ((state_q == WAIT) && lock_s && (cnt_q != CNT_LAST)) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   // Output decode of the FSM
   always_comb begin
      lock_ok = (state_q == RUN);
   end

endmodule

// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - raster counters, sync/enable decode and registered video timing outputs
module video_timing_gen
   import video_timing_pkg::*;
#(
   parameter int   H_ACTIVE  = DEF_H_ACTIVE,
   parameter int   H_FP      = DEF_H_FP,
   parameter int   H_SYNC    = DEF_H_SYNC,
   parameter int   H_BP      = DEF_H_BP,
   parameter int   V_ACTIVE  = DEF_V_ACTIVE,
   parameter int   V_FP      = DEF_V_FP,
   parameter int   V_SYNC    = DEF_V_SYNC,
   parameter int   V_BP      = DEF_V_BP,
   parameter logic HSYNC_POL = DEF_HSYNC_POL,
   parameter logic VSYNC_POL = DEF_VSYNC_POL,
   parameter int   LOCK_WAIT = DEF_LOCK_WAIT
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           pll_locked,
   output logic           running,
   output logic           hsync,
   output logic           vsync,
   output logic           de,
   output logic [H_W-1:0] x,
   output logic [V_W-1:0] y,
   output logic           frame_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HS_BEG  = H_ACTIVE + H_FP;
   localparam int HS_END  = H_ACTIVE + H_FP + H_SYNC;
   localparam int VS_BEG  = V_ACTIVE + V_FP;
   localparam int VS_END  = V_ACTIVE + V_FP + V_SYNC;

   localparam logic [H_W-1:0] H_LAST = H_W'(H_TOTAL - 1);
   localparam logic [V_W-1:0] V_LAST = V_W'(V_TOTAL - 1);

   if (H_TOTAL > 4096) begin : g_h_total_check
      $error("video_timing_gen: H_TOTAL exceeds the 12-bit horizontal counter");
   end
   if (V_TOTAL > 2048) begin : g_v_total_check
      $error("video_timing_gen: V_TOTAL exceeds the 11-bit vertical counter");
   end

   logic           lock_s;
   logic           lock_ok;
   logic           advance;
   logic [H_W-1:0] h_q;
   logic [H_W-1:0] h_d;
   logic [V_W-1:0] v_q;
   logic [V_W-1:0] v_d;

   logic           de_d;
   logic           hs_act;
   logic           vs_act;
   logic           hsync_d;
   logic           vsync_d;
   logic [H_W-1:0] x_d;
   logic [V_W-1:0] y_d;
   logic           frame_start_d;

   lock_qualifier #(
      .LOCK_WAIT (LOCK_WAIT)
   ) u_lock_qualifier (
      .clk        (clk),
      .rst_n      (rst_n),
      .pll_locked (pll_locked),
      .lock_s     (lock_s),
      .lock_ok    (lock_ok)
   );

   // Counters only advance while staying in RUN, so WAIT always sees h=v=0
   assign advance = lock_ok & lock_s;

   // Raster counter next-state: h wraps per line, v steps on each h wrap
   always_comb begin
      h_d = '0;
      v_d = '0;
      if (advance) begin
         if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + V_W'(1);
         end else begin
            h_d = h_q + H_W'(1);
            v_d = v_q;
         end
      end
   end

   // Raster counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_q <= '0;
         v_q <= '0;
      end else begin
         h_q <= h_d;
         v_q <= v_d;
      end
   end

   // Decode of the current counter position; everything idles outside RUN
   always_comb begin
      de_d          = lock_ok && (int'(h_q) < H_ACTIVE) && (int'(v_q) < V_ACTIVE);
      hs_act        = lock_ok && (int'(h_q) >= HS_BEG) && (int'(h_q) < HS_END);
      vs_act        = lock_ok && (int'(v_q) >= VS_BEG) && (int'(v_q) < VS_END);
      hsync_d       = hs_act ? HSYNC_POL : ~HSYNC_POL;
      vsync_d       = vs_act ? VSYNC_POL : ~VSYNC_POL;
      x_d           = de_d ? h_q : '0;
      y_d           = de_d ? v_q : '0;
      frame_start_d = lock_ok && (h_q == '0) && (v_q == '0);
   end

   // Output registers, one cycle behind the counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         running     <= 1'b0;
         hsync       <= ~HSYNC_POL;
         vsync       <= ~VSYNC_POL;
         de          <= 1'b0;
         x           <= '0;
         y           <= '0;
         frame_start <= 1'b0;
      end else begin
         running     <= lock_ok;
         hsync       <= hsync_d;
         vsync       <= vsync_d;
         de          <= de_d;
         x           <= x_d;
         y           <= y_d;
         frame_start <= frame_start_d;
      end
   end

endmodule

// File: tb/tb_video_timing_gen.sv
// tb/tb_video_timing_gen.sv - directed self-checking bench for video_timing_gen in a small mode
module tb_video_timing_gen;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        pll_locked = 1'b0;
   logic        running;
   logic        hsync;
   logic        vsync;
   logic        de;
   logic [11:0] x;
   logic [10:0] y;
   logic        frame_start;

   int n_vec = 0;
   int n_err = 0;
   int k;

   video_timing_gen #(
      .H_ACTIVE  (8),
      .H_FP      (2),
      .H_SYNC    (3),
      .H_BP      (3),
      .V_ACTIVE  (4),
      .V_FP      (1),
      .V_SYNC    (2),
      .V_BP      (1),
      .HSYNC_POL (1'b1),
      .VSYNC_POL (1'b0),
      .LOCK_WAIT (10)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .pll_locked  (pll_locked),
      .running     (running),
      .hsync       (hsync),
      .vsync       (vsync),
      .de          (de),
      .x           (x),
      .y           (y),
      .frame_start (frame_start)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_running(output int cnt);
      cnt = 0;
      while (cnt < 60) begin
         cyc(1);
         cnt++;
         if (running === 1'b1) break;
      end
   endtask

   task automatic check_idle(input string tag);
      chk({tag, ".running"}, running, 0);
      chk({tag, ".hsync"}, hsync, 0);
      chk({tag, ".vsync"}, vsync, 1);
      chk({tag, ".de"}, de, 0);
      chk({tag, ".x"}, x, 0);
      chk({tag, ".y"}, y, 0);
      chk({tag, ".frame_start"}, frame_start, 0);
   endtask

   task automatic check_raster(input int j);
      int h;
      int v;
      int e_de;
      h = j % 16;
      v = (j / 16) % 8;
      e_de = ((h < 8) && (v < 4)) ? 1 : 0;
      chk($sformatf("de@%0d", j), de, e_de);
      chk($sformatf("x@%0d", j), x, (e_de != 0) ? h : 0);
      chk($sformatf("y@%0d", j), y, (e_de != 0) ? v : 0);
      chk($sformatf("hsync@%0d", j), hsync, ((h >= 10) && (h <= 12)) ? 1 : 0);
      chk($sformatf("vsync@%0d", j), vsync, ((v >= 5) && (v <= 6)) ? 0 : 1);
      chk($sformatf("frame_start@%0d", j), frame_start, ((j % 128) == 0) ? 1 : 0);
      chk($sformatf("running@%0d", j), running, 1);
   endtask

   initial begin
      cyc(2);
      check_idle("reset");

      rst_n = 1'b1;
      cyc(4);
      check_idle("unlocked");

      pll_locked = 1'b1;
      wait_running(k);
      chk("startup_latency", k, 13);
      chk("startup_frame_start", frame_start, 1);

      for (int i = 0; i <= 128; i++) begin
         if (i > 0) cyc(1);
         check_raster(i);
      end

      cyc(4);
      chk("loss_pre_x", x, 4);
      chk("loss_pre_de", de, 1);
      pll_locked = 1'b0;
      cyc(3);
      chk("loss_still_running", running, 1);
      cyc(1);
      check_idle("loss_idle");

      cyc(5);
      pll_locked = 1'b1;
      wait_running(k);
      chk("relock_latency", k, 13);
      chk("relock_frame_start", frame_start, 1);
      chk("relock_x", x, 0);
      chk("relock_y", y, 0);
      chk("relock_de", de, 1);

      pll_locked = 1'b0;
      cyc(8);
      check_idle("pre_glitch");
      pll_locked = 1'b1;
      cyc(5);
      pll_locked = 1'b0;
      cyc(1);
      pll_locked = 1'b1;
      wait_running(k);
      chk("glitch_latency", k, 13);

      cyc(90);
      check_raster(90);
      #2;
      rst_n = 1'b0;
      #1;
      check_idle("async_reset");
      cyc(2);
      check_idle("held_reset");
      rst_n = 1'b1;
      wait_running(k);
      chk("post_reset_latency", k, 13);
      chk("post_reset_frame_start", frame_start, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
